// File: rtl/axi_cache_wb.sv
// Set-associative write-back, write-allocate cache controller with tree pseudo-LRU
// replacement, a line-eviction write channel and a beat-wise line-fill read channel.
module axi_cache_wb #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 32,
  parameter int LINE_BYTES = 128,
  parameter int SETS       = 64,
  parameter int WAYS       = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [ADDR_W-1:0]   cpu_addr,
  input  logic [DATA_W-1:0]   cpu_data_in,
  input  logic [DATA_W/8-1:0] cpu_wstb,
  input  logic                cpu_re,
  input  logic                cpu_we,
  output logic [DATA_W-1:0]   cpu_data_out,
  output logic                cpu_ready,
  output logic                miss,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_rd_req,
  input  logic [DATA_W-1:0]   mem_data_in,
  input  logic                mem_data_valid,
  input  logic                mem_last,
  output logic                mem_wr_req,
  output logic [DATA_W-1:0]   mem_data_out,
  output logic [DATA_W/8-1:0] mem_wstb,
  input  logic                mem_wr_ready
);
  localparam int NB     = DATA_W / 8;
  localparam int BEATS  = LINE_BYTES / NB;
  localparam int WB     = $clog2(NB);
  localparam int OFF_W  = $clog2(LINE_BYTES);
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = ADDR_W - OFF_W - IDX_W;
  localparam int LINE_W = ADDR_W - OFF_W;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int LVL    = $clog2(WAYS);
  localparam int PW     = (WAYS > 1) ? WAYS - 1 : 1;

  typedef enum logic [1:0] {READY, EVICT, REPLACE} state_t;

  state_t              state;
  logic [BEAT_W-1:0]   beat;
  logic [LINE_W-1:0]   line_addr;
  logic [WAY_W-1:0]    vic_way;
  logic [WAYS-1:0]     valid [SETS];
  logic [WAYS-1:0]     dirty [SETS];
  logic [PW-1:0]       plru  [SETS];
  logic [TAG_W-1:0]    tag_mem  [WAYS][SETS];
  logic [DATA_W-1:0]   data_mem [WAYS][SETS][BEATS];

  // Tree nodes are heap-ordered; a node bit of 1 steers the victim search right.
  function automatic logic [WAY_W-1:0] plru_victim(input logic [PW-1:0] t);
    int node;
    node = 0;
    for (int l = 0; l < LVL; l++) node = 2 * node + 1 + int'(t[node]);
    return WAY_W'(node - (WAYS - 1));
  endfunction

  function automatic logic [PW-1:0] plru_touch(input logic [PW-1:0] t, input logic [WAY_W-1:0] w);
    logic [PW-1:0] r;
    int node;
    r = t;
    for (int l = 0; l < LVL; l++) begin
      node = (1 << l) - 1 + int'(w >> (LVL - l));
      r[node] = ~w[LVL-1-l];
    end
    return r;
  endfunction

  logic [IDX_W-1:0]  req_idx, l_idx;
  logic [TAG_W-1:0]  req_tag, l_tag;
  logic [BEAT_W-1:0] req_word;
  logic [ADDR_W-1:0] beat_off;
  logic              hit, inv_found, accept, do_hit, do_miss, fill_wr;
  logic [WAY_W-1:0]  hit_way, inv_way, victim;
  logic [DATA_W-1:0] rd_word, wr_word;

  assign req_idx  = cpu_addr[OFF_W +: IDX_W];
  assign req_tag  = cpu_addr[ADDR_W-1 -: TAG_W];
  assign req_word = BEAT_W'(cpu_addr[OFF_W-1:0] >> WB);
  assign l_idx    = line_addr[IDX_W-1:0];
  assign l_tag    = line_addr[IDX_W +: TAG_W];
  assign beat_off = ADDR_W'(beat) << WB;

  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid[req_idx][w] && tag_mem[w][req_idx] == req_tag) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!valid[req_idx][w]) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(w);
      end
    end
    victim = inv_found ? inv_way : plru_victim(plru[req_idx]);
  end

  // A request is taken only while cpu_ready is low so a held request is never served twice.
  assign accept  = (state == READY) && (cpu_re || cpu_we) && !cpu_ready;
  assign do_hit  = accept && hit;
  assign do_miss = accept && !hit;
  assign fill_wr = (state == REPLACE) && mem_data_valid;

  always_comb begin
    rd_word = data_mem[hit_way][req_idx][req_word];
    wr_word = rd_word;
    for (int b = 0; b < NB; b++)
      if (cpu_wstb[b]) wr_word[8*b +: 8] = cpu_data_in[8*b +: 8];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= READY;
      beat         <= '0;
      line_addr    <= '0;
      vic_way      <= '0;
      cpu_ready    <= 1'b0;
      cpu_data_out <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid[s] <= '0;
        dirty[s] <= '0;
        plru[s]  <= '0;
      end
    end else begin
      cpu_ready <= 1'b0;
      case (state)
        READY: begin
          if (do_hit) begin
            cpu_ready     <= 1'b1;
            plru[req_idx] <= plru_touch(plru[req_idx], hit_way);
            if (cpu_we) dirty[req_idx][hit_way] <= 1'b1;
            else        cpu_data_out <= rd_word;
          end else if (do_miss) begin
            line_addr <= cpu_addr[ADDR_W-1:OFF_W];
            vic_way   <= victim;
            beat      <= '0;
            if (valid[req_idx][victim] && dirty[req_idx][victim]) begin
              state <= EVICT;
            end else begin
              valid[req_idx][victim] <= 1'b0;
              state <= REPLACE;
            end
          end
        end
        EVICT: begin
          if (mem_wr_ready) begin
            if (beat == BEAT_W'(BEATS - 1)) begin
              valid[l_idx][vic_way] <= 1'b0;
              dirty[l_idx][vic_way] <= 1'b0;
              beat  <= '0;
              state <= REPLACE;
            end else begin
              beat <= beat + 1'b1;
            end
          end
        end
        REPLACE: begin
          if (mem_data_valid) begin
            if (mem_last) begin
              valid[l_idx][vic_way] <= 1'b1;
              dirty[l_idx][vic_way] <= 1'b0;
              plru[l_idx] <= plru_touch(plru[l_idx], vic_way);
              beat  <= '0;
              state <= READY;
            end else if (beat != BEAT_W'(BEATS - 1)) begin
              beat <= beat + 1'b1;
            end
          end
        end
        default: state <= READY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_hit && cpu_we) data_mem[hit_way][req_idx][req_word] <= wr_word;
    if (fill_wr) data_mem[vic_way][l_idx][beat] <= mem_data_in;
    if (fill_wr && mem_last) tag_mem[vic_way][l_idx] <= l_tag;
  end

  assign miss       = (state != READY);
  assign mem_rd_req = (state == REPLACE);
  assign mem_wr_req = (state == EVICT);

  always_comb begin
    mem_addr     = '0;
    mem_data_out = '0;
    mem_wstb     = '0;
    case (state)
      EVICT: begin
        mem_addr     = (ADDR_W'({tag_mem[vic_way][l_idx], l_idx}) << OFF_W) | beat_off;
        mem_data_out = data_mem[vic_way][l_idx][beat];
        mem_wstb     = '1;
      end
      REPLACE: mem_addr = (ADDR_W'(line_addr) << OFF_W) | beat_off;
      default: ;
    endcase
  end
endmodule

// File: tb/tb_axi_cache_wb.sv
// Scoreboard bench for axi_cache_wb: stimulus queues expected CPU data and memory
// transactions; independent monitor / memory-model processes pop and compare.
module tb_axi_cache_wb;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] cpu_addr = '0;
  logic [31:0] cpu_data_in = '0;
  logic [3:0]  cpu_wstb = '0;
  logic        cpu_re = 1'b0, cpu_we = 1'b0;
  logic [31:0] cpu_data_out;
  logic        cpu_ready, miss;
  logic [15:0] mem_addr;
  logic        mem_rd_req, mem_wr_req;
  logic [31:0] mem_data_in = '0;
  logic        mem_data_valid = 1'b0, mem_last = 1'b0;
  logic [31:0] mem_data_out;
  logic [3:0]  mem_wstb;
  logic        mem_wr_ready = 1'b0;

  always #5 clk = ~clk;

  axi_cache_wb dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_addr(cpu_addr), .cpu_data_in(cpu_data_in), .cpu_wstb(cpu_wstb),
    .cpu_re(cpu_re), .cpu_we(cpu_we),
    .cpu_data_out(cpu_data_out), .cpu_ready(cpu_ready), .miss(miss),
    .mem_addr(mem_addr), .mem_rd_req(mem_rd_req),
    .mem_data_in(mem_data_in), .mem_data_valid(mem_data_valid), .mem_last(mem_last),
    .mem_wr_req(mem_wr_req), .mem_data_out(mem_data_out), .mem_wstb(mem_wstb),
    .mem_wr_ready(mem_wr_ready)
  );

  int n_checks = 0, n_fail = 0;
  logic [31:0] exp_q [$];
  logic [15:0] fill_q [$];
  logic [15:0] ev_q [$];
  logic [31:0] mm [int];
  int fills_seen = 0, evicts_seen = 0;
  int fill_k = 0, ev_j = 0, ev_stall = 0;
  bit fill_active = 0, ev_active = 0;
  logic [15:0] fill_base = '0, ev_base = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mm_rd(input logic [15:0] a);
    return mm.exists(int'(a)) ? mm[int'(a)] : {16'hC0DE, a};
  endfunction

  // CPU-side monitor
  always @(negedge clk) begin
    if (reset_n && cpu_ready) begin
      check("ready_while_miss", 32'(miss), 32'd0);
      if (exp_q.size() == 0) check("unexpected_ready", 32'(cpu_ready), 32'd0);
      else check("cpu_data_out", cpu_data_out, exp_q.pop_front());
    end
  end

  // Memory model: fills one beat per cycle; eviction stalls 3 cycles at beat 5.
  always @(negedge clk) begin
    if (!reset_n) begin
      fill_active = 0; ev_active = 0;
      mem_data_valid = 0; mem_last = 0; mem_wr_ready = 0;
    end else begin
      if (mem_rd_req) begin
        if (!fill_active) begin
          fill_active = 1; fill_k = 0; fills_seen++;
          check("fill_pending", 32'(fill_q.size()), 32'd1);
          fill_base = (fill_q.size() > 0) ? fill_q.pop_front() : 16'h0;
        end
        check("fill_addr", 32'(mem_addr), 32'(fill_base + 16'(4 * fill_k)));
        mem_data_valid = 1; mem_data_in = mm_rd(mem_addr);
        mem_last = (fill_k == 31); fill_k++;
      end else begin
        fill_active = 0; mem_data_valid = 0; mem_last = 0;
      end
      if (mem_wr_req) begin
        if (!ev_active) begin
          ev_active = 1; ev_j = 0; ev_stall = 0; evicts_seen++;
          check("evict_pending", 32'(ev_q.size()), 32'd1);
          ev_base = (ev_q.size() > 0) ? ev_q.pop_front() : 16'h0;
        end
        check("evict_addr", 32'(mem_addr), 32'(ev_base + 16'(4 * ev_j)));
        check("evict_wstb", 32'(mem_wstb), 32'hF);
        if (ev_j == 5 && ev_stall < 3) begin
          mem_wr_ready = 0; ev_stall++;
        end else begin
          mem_wr_ready = 1; mm[int'(mem_addr)] = mem_data_out; ev_j++;
        end
      end else begin
        ev_active = 0; mem_wr_ready = 0;
      end
    end
  end

  task automatic req(input logic [15:0] a, input bit re, input bit we, input logic [31:0] d,
                     input logic [3:0] s, input logic [31:0] exp_d, input bit exp_miss,
                     input bit exp_ev, input logic [15:0] evb);
    int f0, e0, t;
    f0 = fills_seen; e0 = evicts_seen;
    exp_q.push_back(exp_d);
    if (exp_miss) fill_q.push_back({a[15:7], 7'b0});
    if (exp_ev) ev_q.push_back(evb);
    @(negedge clk);
    cpu_addr = a; cpu_re = re; cpu_we = we; cpu_data_in = d; cpu_wstb = s;
    @(posedge clk); #1;
    check("miss_rise", 32'(miss), 32'(exp_miss));
    check("mem_req_rise", 32'(exp_ev ? mem_wr_req : mem_rd_req), 32'(exp_miss));
    t = 0;
    while (!cpu_ready && t < 3000) begin @(posedge clk); #1; t++; end
    check("cpu_ready_seen", 32'(cpu_ready), 32'd1);
    cpu_re = 0; cpu_we = 0;
    @(negedge clk);
    check("fill_count", 32'(fills_seen - f0), 32'(exp_miss));
    check("evict_count", 32'(evicts_seen - e0), 32'(exp_ev));
  endtask

  task automatic rd(input logic [15:0] a, input logic [31:0] exp_d, input bit exp_miss,
                    input bit exp_ev = 0, input logic [15:0] evb = 16'h0);
    req(a, 1'b1, 1'b0, 32'h0, 4'h0, exp_d, exp_miss, exp_ev, evb);
  endtask

  task automatic do_reset();
    @(negedge clk); reset_n = 0;
    repeat (2) @(negedge clk);
    reset_n = 1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    for (int i = 0; i < 32; i++) mm[32'h80 + 4 * i] = 32'hFFFF_FFFF;
    #12;
    check("rst_cpu_ready", 32'(cpu_ready), 32'd0);
    check("rst_miss", 32'(miss), 32'd0);
    check("rst_cpu_data_out", cpu_data_out, 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_rd_req", 32'(mem_rd_req), 32'd0);
    check("rst_mem_wr_req", 32'(mem_wr_req), 32'd0);
    check("rst_mem_data_out", mem_data_out, 32'd0);
    check("rst_mem_wstb", 32'(mem_wstb), 32'd0);
    @(negedge clk); reset_n = 1;

    // Clean fill, then partial write hit and read-back
    rd(16'h0080, 32'hFFFF_FFFF, 1);
    req(16'h0084, 1, 0, 32'h0, 4'b0000, 32'hFFFF_FFFF, 0, 0, 16'h0);
    req(16'h0084, 0, 1, 32'h0000_0000, 4'b0011, 32'hFFFF_FFFF, 0, 0, 16'h0);
    rd(16'h0084, 32'hFFFF_0000, 0);

    // Fill set 1, PLRU picks way 2 (tag 2)
    rd(16'h2080, 32'hC0DE_2080, 1);
    rd(16'h4080, 32'hC0DE_4080, 1);
    rd(16'h6080, 32'hC0DE_6080, 1);
    rd(16'h0080, 32'hFFFF_FFFF, 0);
    rd(16'h8080, 32'hC0DE_8080, 1);
    rd(16'h4080, 32'hC0DE_4080, 1);
    rd(16'h0080, 32'hFFFF_FFFF, 0);

    // Same pattern with 0x4080 dirty: eviction with stall, then fill of 0x8080
    do_reset();
    rd(16'h0080, 32'hFFFF_FFFF, 1);
    rd(16'h2080, 32'hC0DE_2080, 1);
    req(16'h4080, 0, 1, 32'h1234_5678, 4'hF, 32'hC0DE_2080, 1, 0, 16'h0);
    rd(16'h6080, 32'hC0DE_6080, 1);
    rd(16'h0080, 32'hFFFF_FFFF, 0);
    rd(16'h8080, 32'hC0DE_8080, 1, 1, 16'h4080);
    rd(16'h4080, 32'h1234_5678, 1);
    rd(16'h4084, 32'hC0DE_4084, 0);
    rd(16'h0080, 32'hFFFF_FFFF, 0);

    // Reset in the middle of a fill
    do_reset();
    fill_q.push_back(16'h0080);
    @(negedge clk); cpu_addr = 16'h0080; cpu_re = 1;
    t = 0;
    while (!(fill_active && fill_k >= 10) && t < 200) begin @(posedge clk); t++; end
    check("fill_progress", 32'(fill_k >= 10), 32'd1);
    @(posedge clk); #2; reset_n = 0; #1;
    check("mid_rst_miss", 32'(miss), 32'd0);
    check("mid_rst_rd_req", 32'(mem_rd_req), 32'd0);
    cpu_re = 0;
    repeat (2) @(negedge clk);
    reset_n = 1;
    rd(16'h0080, 32'hFFFF_FFFF, 1);

    // Read+write treated as write; dirty line later evicted and written back
    req(16'h0088, 1, 1, 32'h0000_0000, 4'hF, 32'hFFFF_FFFF, 0, 0, 16'h0);
    rd(16'h0088, 32'h0000_0000, 0);
    rd(16'h2080, 32'hC0DE_2080, 1);
    rd(16'h4080, 32'h1234_5678, 1);
    rd(16'h6080, 32'hC0DE_6080, 1);
    rd(16'h8080, 32'hC0DE_8080, 1, 1, 16'h0080);
    rd(16'h0088, 32'h0000_0000, 1);
    rd(16'h008C, 32'hFFFF_FFFF, 0);

    repeat (3) @(negedge clk);
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
